// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and length clamp for the FFT SRAM address sequencer.
package fft_pkg;

  localparam int unsigned FFT_MAX_LOG2 = 9;
  localparam int unsigned FFT_ADDR_W   = FFT_MAX_LOG2;
  localparam int unsigned BF_LAT_DEF   = 3;
  localparam int unsigned LEN_W        = 4;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} fft_state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    if (len == '0) begin
      return LEN_W'(1);
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/fft_wr_addr_delay.sv
// Fixed-latency shift pipe carrying {valid, addr1, addr2} from the read side to the write side.
module fft_wr_addr_delay
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W = FFT_ADDR_W,
  parameter int unsigned DEPTH  = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [ADDR_W-1:0] in_addr2,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr1,
  output logic [ADDR_W-1:0] out_addr2
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr1_q [DEPTH];
  logic [ADDR_W-1:0] addr2_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr1_q[i] <= '0;
        addr2_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr1_q[0] <= in_addr1;
      addr2_q[0] <= in_addr2;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        addr1_q[i] <= addr1_q[i-1];
        addr2_q[i] <= addr2_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr1 = addr1_q[DEPTH-1];
  assign out_addr2 = addr2_q[DEPTH-1];

endmodule

// File: rtl/fft_mem_addr_gen.sv
// Radix-2 DIF in-place address sequencer: butterfly read pairs, twiddle index, delayed write pairs.
module fft_mem_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned MAX_LOG2 = FFT_MAX_LOG2,
  parameter int unsigned BF_LAT   = BF_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          len_log2,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [MAX_LOG2-1:0] rd_addr1,
  output logic [MAX_LOG2-1:0] rd_addr2,
  output logic [MAX_LOG2-2:0] tw_addr,
  output logic                wr_en,
  output logic [MAX_LOG2-1:0] wr_addr1,
  output logic [MAX_LOG2-1:0] wr_addr2,
  output logic [3:0]          stage
);

  localparam int unsigned KW   = MAX_LOG2 - 1;
  localparam int unsigned CntW = $clog2(BF_LAT + 2);

  fft_state_e          state_q, state_d;
  logic [3:0]          stage_q, stage_d;
  logic [3:0]          len_q, len_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]       k_last;

  logic                busy_q, done_q, rd_en_q;
  logic [MAX_LOG2-1:0] rd_addr1_q, rd_addr2_q;
  logic [KW-1:0]       tw_addr_q;

  logic                rd_go;
  logic [3:0]          sh;
  logic [MAX_LOG2-1:0] kx, lo_mask, span, a1;
  logic [KW-1:0]       tw_next;

  // Last butterfly index of a stage is N/2-1.
  assign k_last = {KW{1'b1}} >> (LEN_W'(MAX_LOG2) - len_q);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    len_d   = len_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = clamp_len(len_log2, LEN_W'(MAX_LOG2));
          stage_d = '0;
          k_d     = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (k_q == k_last) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        // Hold off the next stage until the last write of this one has landed.
        if (cnt_q == CntW'(BF_LAT)) begin
          if (stage_q == len_q - 4'd1) begin
            state_d = StDone;
          end else begin
            stage_d = stage_q + 4'd1;
            k_d     = '0;
            state_d = StRead;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Addresses insert a zero at bit (L-1-s) of k: the low bits are j, the high bits the group.
  always_comb begin
    rd_go   = (state_d == StRead);
    sh      = len_d - 4'd1 - stage_d;
    kx      = {1'b0, k_d};
    lo_mask = ~({MAX_LOG2{1'b1}} << sh);
    span    = {{(MAX_LOG2-1){1'b0}}, 1'b1} << sh;
    a1      = ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    tw_next = (k_d & lo_mask[KW-1:0]) << (stage_d + LEN_W'(MAX_LOG2) - len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stage_q    <= '0;
      len_q      <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      tw_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      len_q      <= len_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      rd_en_q    <= rd_go;
      rd_addr1_q <= rd_go ? a1 : '0;
      rd_addr2_q <= rd_go ? (a1 | span) : '0;
      tw_addr_q  <= rd_go ? tw_next : '0;
    end
  end

  fft_wr_addr_delay #(
    .ADDR_W(MAX_LOG2),
    .DEPTH (BF_LAT)
  ) u_wr_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_en_q),
    .in_addr1 (rd_addr1_q),
    .in_addr2 (rd_addr2_q),
    .out_valid(wr_en),
    .out_addr1(wr_addr1),
    .out_addr2(wr_addr2)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr1 = rd_addr1_q;
  assign rd_addr2 = rd_addr2_q;
  assign tw_addr  = tw_addr_q;
  assign stage    = stage_q;

endmodule
